// File: rtl/ixc_sample_queue.sv
// Sample capture queue: strict FIFO of sampled values with sticky overflow and saturating drop count.
// Optional macro IXC_SAMPLE_QUEUE_SEQ_EN adds an 8-bit sequence tag per entry, presented on out_seq.
module ixc_sample_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     do_sample,
   input  logic [WIDTH-1:0]         sv,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [7:0]               out_seq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic [7:0]               drop_cnt,
   input  logic                     ovf_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

   state_t            r_state, w_state_next;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
   logic [AW:0]       r_count, w_count_next;
   logic [WIDTH-1:0]  r_head_data, w_head_data_next;
   logic              r_ovf;
   logic [7:0]        r_drop_cnt;
   logic              w_full, w_pop, w_push, w_drop;
   logic              w_head_load, w_head_from_sv;

   assign out_valid    = (r_state != S_EMPTY);
   assign w_full       = (r_count == C_FULL);
   assign w_pop        = out_valid & out_ready;
   assign w_push       = do_sample & (~w_full | w_pop);
   assign w_drop       = do_sample & w_full & ~w_pop;
   assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
   assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   // The head register must already hold the next entry when the pop edge retires the current one;
   // it comes from sv whenever the queue would otherwise be empty after this cycle.
   always_comb begin
      w_head_load    = 1'b0;
      w_head_from_sv = 1'b0;
      if (w_pop && (r_count != C_ONE)) begin
         w_head_load = 1'b1;
      end else if (w_push && ((r_count == '0) || w_pop)) begin
         w_head_load    = 1'b1;
         w_head_from_sv = 1'b1;
      end
   end

   assign w_head_data_next = w_head_from_sv ? sv : r_mem[w_rd_ptr_inc];

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= sv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_head_data <= '0;
         r_ovf       <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
         r_count <= w_count_next;
         if (w_head_load) r_head_data <= w_head_data_next;
         // A drop coinciding with a clear counts as the first drop after the clear.
         if (w_drop) begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= ovf_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
         end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_EMPTY:   if (w_push) w_state_next = S_PARTIAL;
         S_PARTIAL: begin
            if (w_count_next == '0)         w_state_next = S_EMPTY;
            else if (w_count_next == C_FULL) w_state_next = S_FULL;
         end
         S_FULL:    if (w_pop && !w_push) w_state_next = S_PARTIAL;
         default:   w_state_next = S_EMPTY;
      endcase
   end

`ifdef IXC_SAMPLE_QUEUE_SEQ_EN
   logic [7:0] r_seq_cnt;
   logic [7:0] r_seq_mem [DEPTH];
   logic [7:0] r_head_seq;
   logic [7:0] w_head_seq_next;

   assign w_head_seq_next = w_head_from_sv ? r_seq_cnt : r_seq_mem[w_rd_ptr_inc];

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_seq_mem[r_wr_ptr] <= r_seq_cnt;
      end
   end

   // Dropped pulses still consume a tag so the consumer can see gaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq_cnt  <= '0;
         r_head_seq <= '0;
      end else begin
         if (do_sample)   r_seq_cnt  <= r_seq_cnt + 8'd1;
         if (w_head_load) r_head_seq <= w_head_seq_next;
      end
   end

   assign out_seq = r_head_seq;
`else
   assign out_seq = '0;
`endif

   assign out_data = r_head_data;
   assign count    = r_count;
   assign ovf      = r_ovf;
   assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_ixc_sample_queue.sv
// Self-checking bench for ixc_sample_queue: directed scenarios plus randomized traffic against a queue model.
module tb_ixc_sample_queue;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef IXC_SAMPLE_QUEUE_SEQ_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             do_sample = 1'b0;
   logic [WIDTH-1:0] sv = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [7:0]       out_seq;
   logic [2:0]       count;
   logic             ovf;
   logic [7:0]       drop_cnt;
   logic             ovf_clr = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Model: queue entries are {tag, data}
   logic [15:0] m_q[$];
   bit          m_ovf = 1'b0;
   int          m_drop = 0;
   int          m_seq = 0;
   bit          m_live = 1'b0;

   ixc_sample_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .do_sample(do_sample), .sv(sv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_seq(out_seq), .count(count), .ovf(ovf), .drop_cnt(drop_cnt),
      .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int tagx(int v);
      return SEQ_EN ? v : 0;
   endfunction

   task automatic model_step(bit r, bit ds, logic [7:0] d, bit rdy, bit clr);
      bit pop, full, drop;
      if (r) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_drop = 0;
         m_seq = 0;
      end else begin
         pop  = (m_q.size() != 0) && rdy;
         full = (m_q.size() == DEPTH);
         drop = 1'b0;
         if (pop) void'(m_q.pop_front());
         if (ds) begin
            if (!full || pop) m_q.push_back({8'(tagx(m_seq)), d});
            else drop = 1'b1;
            m_seq = (m_seq + 1) % 256;
         end
         if (drop) begin
            m_ovf = 1'b1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
         end else if (clr) begin
            m_ovf = 1'b0;
            m_drop = 0;
         end
      end
      m_live = 1'b1;
   endtask

   task automatic cyc(bit r, bit ds, logic [7:0] d, bit rdy, bit clr);
      rst = r; do_sample = ds; sv = d; out_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      model_step(r, ds, d, rdy, clr);
      #2;
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         chk("count", int'(count), m_q.size());
         chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("drop_cnt", int'(drop_cnt), m_drop);
         if (m_q.size() != 0) begin
            chk("out_data", int'(out_data), int'(m_q[0][7:0]));
            chk("out_seq", int'(out_seq), int'(m_q[0][15:8]));
         end
      end
   end

   initial begin
      int thr;
      // Single sample
      cyc(1, 0, 8'h00, 0, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_seq", int'(out_seq), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      cyc(0, 1, 8'hA5, 1, 0);
      chk("single_valid", int'(out_valid), 1);
      chk("single_data", int'(out_data), 8'hA5);
      chk("single_count", int'(count), 1);
      cyc(0, 0, 8'h00, 1, 0);
      chk("single_gone_valid", int'(out_valid), 0);
      chk("single_gone_count", int'(count), 0);

      // Fill and overflow
      cyc(1, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 5; k++) cyc(0, 1, 8'(k), 0, 0);
      chk("fill_count", int'(count), 4);
      chk("fill_ovf", int'(ovf), 1);
      chk("fill_drop", int'(drop_cnt), 1);
      for (int k = 1; k <= 4; k++) begin
         chk("fill_drain", int'(out_data), k);
         cyc(0, 0, 8'h00, 1, 0);
      end
      chk("fill_empty", int'(out_valid), 0);

      // Push and pop while full
      cyc(1, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 4; k++) cyc(0, 1, 8'(k), 0, 0);
      cyc(0, 1, 8'h77, 1, 0);
      chk("pp_count", int'(count), 4);
      chk("pp_ovf", int'(ovf), 0);
      for (int k = 0; k < 4; k++) begin
         chk("pp_drain", int'(out_data), (k == 3) ? 8'h77 : k + 2);
         cyc(0, 0, 8'h00, 1, 0);
      end

      // Saturation and clear
      cyc(1, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 4; k++) cyc(0, 1, 8'(k), 0, 0);
      for (int k = 0; k < 300; k++) cyc(0, 1, 8'hEE, 0, 0);
      chk("sat_drop", int'(drop_cnt), 255);
      chk("sat_ovf", int'(ovf), 1);
      cyc(0, 1, 8'hEE, 0, 1);
      chk("clr_drop_ovf", int'(ovf), 1);
      chk("clr_drop_cnt", int'(drop_cnt), 1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("clr_ovf", int'(ovf), 0);
      chk("clr_cnt", int'(drop_cnt), 0);

      // Reset mid-operation
      cyc(1, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 3; k++) cyc(0, 1, 8'(k), 0, 0);
      chk("mid_count3", int'(count), 3);
      cyc(1, 1, 8'h55, 1, 1);
      chk("mid_count", int'(count), 0);
      chk("mid_valid", int'(out_valid), 0);
      chk("mid_ovf", int'(ovf), 0);
      cyc(0, 0, 8'h00, 0, 0);
      chk("mid_after_valid", int'(out_valid), 0);
      chk("mid_after_count", int'(count), 0);

      // Sequence tags with a dropped pulse
      cyc(1, 0, 8'h00, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 8'(8'h10 + k), 0, 0);
      cyc(0, 1, 8'h99, 0, 0);
      cyc(0, 1, 8'h20, 1, 0);
      for (int k = 0; k < 4; k++) begin
         chk("seq_tag", int'(out_seq), tagx((k == 3) ? 5 : k + 1));
         cyc(0, 0, 8'h00, 1, 0);
      end

      // Randomized traffic
      thr = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) thr = (c / 200 % 3 == 0) ? 15 : ((c / 200 % 3 == 1) ? 50 : 90);
         cyc($urandom_range(0, 99) < 2,
             $urandom_range(0, 1) == 1,
             8'($urandom),
             $urandom_range(0, 99) < thr,
             $urandom_range(0, 99) < 3);
      end
      cyc(0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
